// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// ysyx_23060025_axi_arbiter_pkg: arbiter state encodings, AXI response codes and grant priority
// Exports: IDLE/IFU_RD/LSU_RD/LSU_WR state codes, RESP_* response codes, grant() next-owner function
package ysyx_23060025_axi_arbiter_pkg;
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFU_RD = 2'd1;
  localparam logic [1:0] LSU_RD = 2'd2;
  localparam logic [1:0] LSU_WR = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  // An IFU that lost the previous round to the LSU goes first; otherwise writes beat reads.
  function automatic state_t grant(input logic last_lsu, input logic ifu_v, input logic aw_v, input logic ar_v);
    return last_lsu & ifu_v ? IFU_RD : aw_v ? LSU_WR : ar_v ? LSU_RD : ifu_v ? IFU_RD : IDLE;
  endfunction
endpackage

// File: rtl/ysyx_23060025_axi_arbiter_if.sv
// ysyx_23060025_axi_arbiter_if: AXI4-Lite channel bundle (AR/R/AW/W/B)
// Modports: master drives requests, slave answers them, rd_slave is the read-only answering side
interface ysyx_23060025_axi_arbiter_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic [ADDR_LEN-1:0]   ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_LEN-1:0]   r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_LEN-1:0]   aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_LEN-1:0]   w_data;
  logic [DATA_LEN/8-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  modport master (
    output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );
  modport slave (
    input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );
  modport rd_slave (
    input  ar_addr, ar_valid, r_ready,
    output ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/ysyx_23060025_axi_arbiter.sv
// ysyx_23060025_axi_arbiter: 2-master (IFU read-only, LSU read/write) to 1-slave AXI4-Lite arbiter
// Ports: clk, rstn (async active-low); ifu = IFU AR/R, lsu = LSU AR/R/AW/W/B, m = slave-facing channels
module ysyx_23060025_axi_arbiter
  import ysyx_23060025_axi_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input logic clk,
  input logic rstn,
  ysyx_23060025_axi_arbiter_if.rd_slave ifu,
  ysyx_23060025_axi_arbiter_if.slave    lsu,
  ysyx_23060025_axi_arbiter_if.master   m
);
  logic [1:0] state, state_n;
  logic last_lsu, last_n, g_ifu, g_lrd, g_lwr;
  assign g_ifu = state == IFU_RD;
  assign g_lrd = state == LSU_RD;
  assign g_lwr = state == LSU_WR;
  // Readies are gated by ownership, so a completed handshake can only come from the owner's channel.
  assign state_n = state == IDLE ? grant(last_lsu, ifu.ar_valid, lsu.aw_valid, lsu.ar_valid)
                 : (m.r_valid & m.r_ready) | (m.b_valid & m.b_ready) ? IDLE : state;
  assign last_n = state == IDLE && state_n != IDLE ? state_n != IFU_RD : last_lsu;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      last_lsu <= 1'b0;
    end else begin
      state    <= state_n;
      last_lsu <= last_n;
    end
  assign m.ar_addr  = {ADDR_LEN{g_ifu}} & ifu.ar_addr | {ADDR_LEN{g_lrd}} & lsu.ar_addr;
  assign m.ar_valid = g_ifu & ifu.ar_valid | g_lrd & lsu.ar_valid;
  assign m.r_ready  = g_ifu & ifu.r_ready | g_lrd & lsu.r_ready;
  assign ifu.ar_ready = g_ifu & m.ar_ready;
  assign ifu.r_data   = {DATA_LEN{g_ifu}} & m.r_data;
  assign ifu.r_resp   = {2{g_ifu}} & m.r_resp;
  assign ifu.r_valid  = g_ifu & m.r_valid;
  assign lsu.ar_ready = g_lrd & m.ar_ready;
  assign lsu.r_data   = {DATA_LEN{g_lrd}} & m.r_data;
  assign lsu.r_resp   = {2{g_lrd}} & m.r_resp;
  assign lsu.r_valid  = g_lrd & m.r_valid;
  assign m.aw_addr  = {ADDR_LEN{g_lwr}} & lsu.aw_addr;
  assign m.aw_valid = g_lwr & lsu.aw_valid;
  assign m.w_data   = {DATA_LEN{g_lwr}} & lsu.w_data;
  assign m.w_strb   = {(DATA_LEN/8){g_lwr}} & lsu.w_strb;
  assign m.w_valid  = g_lwr & lsu.w_valid;
  assign m.b_ready  = g_lwr & lsu.b_ready;
  assign lsu.aw_ready = g_lwr & m.aw_ready;
  assign lsu.w_ready  = g_lwr & m.w_ready;
  assign lsu.b_resp   = {2{g_lwr}} & m.b_resp;
  assign lsu.b_valid  = g_lwr & m.b_valid;
endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// tb_ysyx_23060025_axi_arbiter: table, directed and random checks of the arbiter against an ownership model
module tb_ysyx_23060025_axi_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  ysyx_23060025_axi_arbiter_if ifu_bus ();
  ysyx_23060025_axi_arbiter_if lsu_bus ();
  ysyx_23060025_axi_arbiter_if m_bus ();
  ysyx_23060025_axi_arbiter dut (.clk(clk), .rstn(rstn), .ifu(ifu_bus), .lsu(lsu_bus), .m(m_bus));
  typedef struct {
    logic [31:0] ifu_ar_addr;
    logic        ifu_ar_valid;
    logic        ifu_r_ready;
    logic [31:0] lsu_ar_addr;
    logic        lsu_ar_valid;
    logic        lsu_r_ready;
    logic [31:0] lsu_aw_addr;
    logic        lsu_aw_valid;
    logic [31:0] lsu_w_data;
    logic [3:0]  lsu_w_strb;
    logic        lsu_w_valid;
    logic        lsu_b_ready;
    logic        m_ar_ready;
    logic [31:0] m_r_data;
    logic [1:0]  m_r_resp;
    logic        m_r_valid;
    logic        m_aw_ready;
    logic        m_w_ready;
    logic [1:0]  m_b_resp;
    logic        m_b_valid;
  } in_t;
  typedef struct {
    logic       iv, rv, wv, mrv, mbv;
    logic [4:0] exp;
  } vec_t;
  typedef logic [181:0] out_t;
  in_t cur;
  vec_t vecs[12];
  int checks = 0;
  int errors = 0;
  int own = 0;
  bit fav_ifu = 1'b0;
  function automatic out_t dut_out();
    return {ifu_bus.ar_ready, ifu_bus.r_data, ifu_bus.r_resp, ifu_bus.r_valid,
            lsu_bus.ar_ready, lsu_bus.r_data, lsu_bus.r_resp, lsu_bus.r_valid,
            lsu_bus.aw_ready, lsu_bus.w_ready, lsu_bus.b_resp, lsu_bus.b_valid,
            m_bus.ar_addr, m_bus.ar_valid, m_bus.r_ready, m_bus.aw_addr, m_bus.aw_valid,
            m_bus.w_data, m_bus.w_strb, m_bus.w_valid, m_bus.b_ready};
  endfunction
  // own: 0 = bus free, 1 = IFU read, 2 = LSU read, 3 = LSU write; the owner's channels are routed, everyone else sees zeros.
  function automatic out_t model_out(int o, in_t x);
    logic gi, gr, gw;
    gi = o == 1;
    gr = o == 2;
    gw = o == 3;
    return {gi & x.m_ar_ready, gi ? x.m_r_data : 32'h0, gi ? x.m_r_resp : 2'b0, gi & x.m_r_valid,
            gr & x.m_ar_ready, gr ? x.m_r_data : 32'h0, gr ? x.m_r_resp : 2'b0, gr & x.m_r_valid,
            gw & x.m_aw_ready, gw & x.m_w_ready, gw ? x.m_b_resp : 2'b0, gw & x.m_b_valid,
            gi ? x.ifu_ar_addr : gr ? x.lsu_ar_addr : 32'h0,
            (gi & x.ifu_ar_valid) | (gr & x.lsu_ar_valid),
            (gi & x.ifu_r_ready) | (gr & x.lsu_r_ready),
            gw ? x.lsu_aw_addr : 32'h0, gw & x.lsu_aw_valid,
            gw ? x.lsu_w_data : 32'h0, gw ? x.lsu_w_strb : 4'h0, gw & x.lsu_w_valid, gw & x.lsu_b_ready};
  endfunction
  task automatic model_step(input in_t x);
    if (own == 0) begin
      if (fav_ifu && x.ifu_ar_valid) own = 1;
      else if (x.lsu_aw_valid) own = 3;
      else if (x.lsu_ar_valid) own = 2;
      else if (x.ifu_ar_valid) own = 1;
      if (own != 0) fav_ifu = own != 1;
    end else if (own == 3 ? (x.m_b_valid && x.lsu_b_ready)
                          : (x.m_r_valid && (own == 1 ? x.ifu_r_ready : x.lsu_r_ready))) own = 0;
  endtask
  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic apply();
    ifu_bus.ar_addr  = cur.ifu_ar_addr;
    ifu_bus.ar_valid = cur.ifu_ar_valid;
    ifu_bus.r_ready  = cur.ifu_r_ready;
    lsu_bus.ar_addr  = cur.lsu_ar_addr;
    lsu_bus.ar_valid = cur.lsu_ar_valid;
    lsu_bus.r_ready  = cur.lsu_r_ready;
    lsu_bus.aw_addr  = cur.lsu_aw_addr;
    lsu_bus.aw_valid = cur.lsu_aw_valid;
    lsu_bus.w_data   = cur.lsu_w_data;
    lsu_bus.w_strb   = cur.lsu_w_strb;
    lsu_bus.w_valid  = cur.lsu_w_valid;
    lsu_bus.b_ready  = cur.lsu_b_ready;
    m_bus.ar_ready   = cur.m_ar_ready;
    m_bus.r_data     = cur.m_r_data;
    m_bus.r_resp     = cur.m_r_resp;
    m_bus.r_valid    = cur.m_r_valid;
    m_bus.aw_ready   = cur.m_aw_ready;
    m_bus.w_ready    = cur.m_w_ready;
    m_bus.b_resp     = cur.m_b_resp;
    m_bus.b_valid    = cur.m_b_valid;
  endtask
  task automatic drive(input string name);
    @(negedge clk);
    apply();
    #1;
    chk({name, " model"}, dut_out(), rstn ? model_out(own, cur) : '0);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step(cur);
    else begin
      own = 0;
      fav_ifu = 1'b0;
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    cur = '{default: '0};
    drive("reset");
    tick();
    #1 rstn = 1'b1;
  endtask
  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction
  initial begin
    ifu_bus.aw_addr = '0; ifu_bus.aw_valid = 1'b0; ifu_bus.w_data = '0; ifu_bus.w_strb = '0;
    ifu_bus.w_valid = 1'b0; ifu_bus.b_ready = 1'b0; ifu_bus.aw_ready = 1'b0; ifu_bus.w_ready = 1'b0;
    ifu_bus.b_resp = '0; ifu_bus.b_valid = 1'b0;
    vecs[0]  = '{1, 1, 1, 0, 0, 5'b00000};
    vecs[1]  = '{1, 1, 1, 0, 0, 5'b00101};
    vecs[2]  = '{1, 1, 0, 0, 1, 5'b00101};
    vecs[3]  = '{1, 1, 0, 0, 0, 5'b00000};
    vecs[4]  = '{1, 1, 0, 1, 0, 5'b10010};
    vecs[5]  = '{1, 1, 0, 0, 0, 5'b00000};
    vecs[6]  = '{1, 1, 0, 0, 0, 5'b01010};
    vecs[7]  = '{0, 1, 0, 1, 0, 5'b01010};
    vecs[8]  = '{1, 0, 0, 0, 0, 5'b00000};
    vecs[9]  = '{1, 0, 0, 0, 1, 5'b10010};
    vecs[10] = '{1, 0, 0, 1, 0, 5'b10010};
    vecs[11] = '{0, 0, 0, 0, 0, 5'b00000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cur = '{default: '0};
      cur.ifu_ar_addr = 32'h8000_0000 + 32'(i);
      cur.lsu_ar_addr = 32'h8000_2000 + 32'(i);
      cur.lsu_aw_addr = 32'h8000_3000 + 32'(i);
      {cur.m_ar_ready, cur.m_aw_ready, cur.m_w_ready, cur.ifu_r_ready, cur.lsu_r_ready, cur.lsu_b_ready} = '1;
      cur.ifu_ar_valid = vecs[i].iv;
      cur.lsu_ar_valid = vecs[i].rv;
      cur.lsu_aw_valid = vecs[i].wv;
      cur.lsu_w_valid  = vecs[i].wv;
      cur.m_r_valid    = vecs[i].mrv;
      cur.m_b_valid    = vecs[i].mbv;
      drive($sformatf("vec%0d", i));
      chk($sformatf("vec%0d readies", i),
          {ifu_bus.ar_ready, lsu_bus.ar_ready, lsu_bus.aw_ready, m_bus.r_ready, m_bus.b_ready}, vecs[i].exp);
      tick();
    end
    do_reset();
    cur.ifu_ar_valid = 1'b1;
    cur.ifu_ar_addr = 32'h8000_0000;
    cur.m_ar_ready = 1'b1;
    cur.ifu_r_ready = 1'b1;
    drive("ifu_req");
    chk("ifu_ar_ready_cycle0", ifu_bus.ar_ready, 1'b0);
    tick();
    drive("ifu_ar");
    chk("ifu_ar_ready_cycle1", ifu_bus.ar_ready, 1'b1);
    chk("ifu_m_ar_addr", m_bus.ar_addr, 32'h8000_0000);
    tick();
    cur.ifu_ar_valid = 1'b0;
    cur.m_r_valid = 1'b1;
    cur.m_r_data = 32'h0000_0413;
    cur.m_r_resp = 2'b00;
    drive("ifu_r");
    chk("ifu_r_data", ifu_bus.r_data, 32'h0000_0413);
    chk("ifu_r_valid", ifu_bus.r_valid, 1'b1);
    chk("ifu_r_resp", {ifu_bus.r_resp, m_bus.r_ready}, 3'b001);
    tick();
    drive("ifu_idle");
    chk("ifu_back_to_idle", {ifu_bus.r_valid, m_bus.r_ready, ifu_bus.ar_ready}, 3'b000);
    tick();
    do_reset();
    cur.lsu_ar_valid = 1'b1;
    cur.lsu_ar_addr = 32'h8000_2000;
    cur.m_ar_ready = 1'b1;
    drive("bp_req");
    tick();
    drive("bp_ar");
    chk("bp_lsu_ar_ready", lsu_bus.ar_ready, 1'b1);
    tick();
    cur.lsu_ar_valid = 1'b0;
    cur.m_r_valid = 1'b1;
    cur.m_r_resp = 2'b11;
    cur.m_r_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      drive("bp_hold");
      chk("bp_m_r_ready_low", m_bus.r_ready, 1'b0);
      chk("bp_still_lsu_rd", {lsu_bus.ar_ready, lsu_bus.r_valid}, 2'b11);
      tick();
    end
    cur.lsu_r_ready = 1'b1;
    drive("bp_release");
    chk("bp_m_r_ready_high", m_bus.r_ready, 1'b1);
    chk("err_r_resp_decerr", lsu_bus.r_resp, 2'b11);
    chk("err_r_data", lsu_bus.r_data, 32'h1234_5678);
    tick();
    drive("err_no_retry");
    chk("err_idle_no_retry", {lsu_bus.ar_ready, lsu_bus.r_valid, m_bus.r_ready}, 3'b000);
    tick();
    do_reset();
    cur.lsu_w_valid = 1'b1;
    cur.lsu_w_data = 32'hDEAD_BEEF;
    cur.lsu_w_strb = 4'b0011;
    {cur.m_aw_ready, cur.m_w_ready, cur.lsu_b_ready, cur.m_ar_ready} = '1;
    for (int i = 0; i < 2; i++) begin
      drive("w_early");
      chk("w_waits_for_aw", {lsu_bus.w_ready, m_bus.w_valid, ifu_bus.ar_ready}, 3'b000);
      tick();
    end
    cur.lsu_aw_valid = 1'b1;
    cur.lsu_aw_addr = 32'h8000_1000;
    drive("aw_arb");
    chk("aw_arb_no_ready", {lsu_bus.aw_ready, lsu_bus.w_ready}, 2'b00);
    tick();
    drive("wr_pass");
    chk("wr_m_w_data", m_bus.w_data, 32'hDEAD_BEEF);
    chk("wr_m_w_strb", m_bus.w_strb, 4'b0011);
    chk("wr_m_aw_addr", m_bus.aw_addr, 32'h8000_1000);
    chk("wr_valids_readies", {m_bus.aw_valid, m_bus.w_valid, lsu_bus.aw_ready, lsu_bus.w_ready, ifu_bus.ar_ready}, 5'b11110);
    tick();
    cur.lsu_aw_valid = 1'b0;
    cur.lsu_w_valid = 1'b0;
    cur.m_b_valid = 1'b1;
    cur.m_b_resp = 2'b10;
    drive("wr_b");
    chk("wr_b_valid_resp", {lsu_bus.b_valid, lsu_bus.b_resp, m_bus.b_ready}, 4'b1101);
    tick();
    drive("wr_done");
    chk("wr_b_done_idle", {lsu_bus.b_valid, m_bus.b_ready}, 2'b00);
    tick();
    do_reset();
    {cur.lsu_aw_valid, cur.lsu_w_valid, cur.m_aw_ready, cur.m_w_ready, cur.lsu_b_ready} = '1;
    cur.lsu_aw_addr = 32'h8000_4000;
    cur.lsu_w_data = 32'hCAFE_F00D;
    cur.lsu_w_strb = 4'hF;
    cur.ifu_ar_valid = 1'b1;
    cur.ifu_ar_addr = 32'h8000_0100;
    cur.m_ar_ready = 1'b1;
    cur.ifu_r_ready = 1'b1;
    drive("rst_req");
    tick();
    drive("rst_aw");
    chk("rst_aw_handshake", lsu_bus.aw_ready, 1'b1);
    tick();
    cur.lsu_aw_valid = 1'b0;
    cur.m_b_valid = 1'b1;
    drive("rst_mid_wr");
    #2 rstn = 1'b0;
    #1 chk("rst_async_outputs_zero", dut_out(), '0);
    tick();
    cur.lsu_w_valid = 1'b0;
    cur.m_b_valid = 1'b0;
    drive("rst_hold");
    tick();
    #1 rstn = 1'b1;
    drive("rel_idle");
    chk("rel_idle_no_ready", ifu_bus.ar_ready, 1'b0);
    tick();
    drive("rel_grant");
    chk("rel_ifu_granted", {ifu_bus.ar_ready, m_bus.ar_addr}, {1'b1, 32'h8000_0100});
    tick();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cur.ifu_ar_addr  = $urandom;
      cur.ifu_ar_valid = rb();
      cur.ifu_r_ready  = rb();
      cur.lsu_ar_addr  = $urandom;
      cur.lsu_ar_valid = rb();
      cur.lsu_r_ready  = rb();
      cur.lsu_aw_addr  = $urandom;
      cur.lsu_aw_valid = rb();
      cur.lsu_w_data   = $urandom;
      cur.lsu_w_strb   = 4'($urandom);
      cur.lsu_w_valid  = rb();
      cur.lsu_b_ready  = rb();
      cur.m_ar_ready   = rb();
      cur.m_r_data     = $urandom;
      cur.m_r_resp     = 2'($urandom);
      cur.m_r_valid    = rb();
      cur.m_aw_ready   = rb();
      cur.m_w_ready    = rb();
      cur.m_b_resp     = 2'($urandom);
      cur.m_b_valid    = rb();
      drive("rand");
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
